// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, strobe
// polarity, word geometry and the control unit's load/store opcodes.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam logic STROBE_ACTIVE  = 1'b0;
  localparam int   BYTES_PER_WORD = 4;

  localparam logic [5:0] OP_SW = 6'b100110;
  localparam logic [5:0] OP_LW = 6'b100111;

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-wide storage with a 4-byte big-endian write port and a registered
// 4-byte read port. Only the read register is reset.
module dmem_byte_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [7:0] mem [DEPTH];

  // NOTE: the storage array is deliberately left without a reset so it maps
  // onto plain RAM; a reset would force it into thousands of flops.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        mem[addr + AW'(i)] <= wdata[31-8*i -: 8];
      end
    end
  end

  // Byte 0 of the word lands in the most significant lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        rdata[31-8*i -: 8] <= mem[addr + AW'(i)];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts active-low RD/WR strobes, inserts WAIT_CYCLES
// wait states, stalls the CPU through Busy and pulses Done/AddrErr/ProtoErr.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        RD,
  input  logic        WR,
  input  logic [31:0] DAddr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        Busy,
  output logic        Done,
  output logic        AddrErr,
  output logic        ProtoErr
);

  localparam int AW = $clog2(DEPTH);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          op_write_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   data_q;

  logic rd_low, wr_low, req, both_low, aligned;
  logic latch, mem_we, mem_re, done_d, addr_err_d, proto_err_d;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  // Upper address bits are discarded by the modulo-DEPTH wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^DAddr[31:AW];

  assign rd_low   = (RD == STROBE_ACTIVE);
  assign wr_low   = (WR == STROBE_ACTIVE);
  assign req      = rd_low ^ wr_low;
  assign both_low = rd_low & wr_low;
  assign aligned  = (DAddr[1:0] == 2'b00);

  assign Busy = ((state_q == IDLE) && req) || (state_q == WAIT);

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    latch       = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    done_d      = 1'b0;
    addr_err_d  = 1'b0;
    proto_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (both_low) begin
          proto_err_d = 1'b1;
        end else if (req && aligned) begin
          latch = 1'b1;
          cnt_d = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            done_d  = 1'b1;
            mem_we  = wr_low;
            mem_re  = rd_low;
          end else begin
            state_d = WAIT;
          end
        end else if (req) begin
          addr_err_d = 1'b1;
          state_d    = RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          done_d  = 1'b1;
          mem_we  = op_write_q;
          mem_re  = !op_write_q;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      Done       <= 1'b0;
      AddrErr    <= 1'b0;
      ProtoErr   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      Done     <= done_d;
      AddrErr  <= addr_err_d;
      ProtoErr <= proto_err_d;
      if (latch) begin
        op_write_q <= wr_low;
        addr_q     <= DAddr[AW-1:0];
        data_q     <= DataIn;
      end
    end
  end

  // With zero wait states the access completes from IDLE, before the latch.
  assign mem_addr  = (state_q == IDLE) ? DAddr[AW-1:0] : addr_q;
  assign mem_wdata = (state_q == IDLE) ? DataIn : data_q;

  dmem_byte_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (CLK),
    .rst   (Reset),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (DataOut)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: one instance with two wait states,
// one with none, both checked against a byte-array reference model.
module tb_data_mem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] daddr [2];
  logic [31:0] din   [2];
  logic [31:0] dout  [2];
  logic        busy  [2];
  logic        done  [2];
  logic        aerr  [2];
  logic        perr  [2];

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut_w2 (
    .CLK(clk), .Reset(rst[0]), .RD(rd[0]), .WR(wr[0]), .DAddr(daddr[0]),
    .DataIn(din[0]), .DataOut(dout[0]), .Busy(busy[0]), .Done(done[0]),
    .AddrErr(aerr[0]), .ProtoErr(perr[0])
  );

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut_w0 (
    .CLK(clk), .Reset(rst[1]), .RD(rd[1]), .WR(wr[1]), .DAddr(daddr[1]),
    .DataIn(din[1]), .DataOut(dout[1]), .Busy(busy[1]), .Done(done[1]),
    .AddrErr(aerr[1]), .ProtoErr(perr[1])
  );

  // Reference model: byte memory and last successfully loaded word per DUT.
  logic [7:0]  mem_m  [2][256];
  logic [31:0] dout_m [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // kind: 0 = load, 1 = store, 2 = both strobes low.
  task automatic access(input int d, input int kind, input logic [31:0] a, input logic [31:0] data);
    int n;
    int base;
    int exp_stall;
    logic is_aligned;
    daddr[d] = a;
    din[d]   = data;
    rd[d]    = (kind == 0 || kind == 2) ? 1'b0 : 1'b1;
    wr[d]    = (kind == 1 || kind == 2) ? 1'b0 : 1'b1;
    #1;
    if (kind == 2) begin
      check("proto_busy", 32'(busy[d]), 32'd0);
      @(posedge clk); #1;
      rd[d] = 1'b1;
      wr[d] = 1'b1;
      check("proto_err", 32'(perr[d]), 32'd1);
      check("proto_done", 32'(done[d]), 32'd0);
      check("proto_dout", dout[d], dout_m[d]);
      @(posedge clk); #1;
      check("proto_pulse", 32'(perr[d]), 32'd0);
      return;
    end
    is_aligned = (a[1:0] == 2'b00);
    exp_stall  = is_aligned ? 1 + wait_of(d) : 1;
    n = 0;
    while (busy[d] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_cycles", 32'(n), 32'(exp_stall));
    if (is_aligned) begin
      base = int'(a % 256);
      if (kind == 1) begin
        for (int i = 0; i < 4; i++) mem_m[d][base + i] = data[31-8*i -: 8];
      end else begin
        for (int i = 0; i < 4; i++) dout_m[d][31-8*i -: 8] = mem_m[d][base + i];
      end
    end
    check("done", 32'(done[d]), 32'(is_aligned));
    check("addr_err", 32'(aerr[d]), 32'(!is_aligned));
    check("resp_busy", 32'(busy[d]), 32'd0);
    check("dout", dout[d], dout_m[d]);
    // Strobes stay asserted through RESP, as the control unit would hold them.
    @(posedge clk); #1;
    check("done_pulse", 32'(done[d]), 32'd0);
    check("addr_err_pulse", 32'(aerr[d]), 32'd0);
    rd[d] = 1'b1;
    wr[d] = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    int r;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; rd[d] = 1'b1; wr[d] = 1'b1; daddr[d] = '0; din[d] = '0;
      dout_m[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_dout", dout[d], 32'd0);
      check("rst_busy", 32'(busy[d]), 32'd0);
      check("rst_flags", {29'd0, done[d], aerr[d], perr[d]}, 32'd0);
      rst[d] = 1'b0;
    end
    @(posedge clk); #1;

    // Give every word a known value so the model matches the unreset array.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 64; w++) access(d, 1, 32'(w * 4), $urandom);
    end

    // Directed cases.
    access(0, 1, 32'h08, 32'hDEADBEEF);
    access(0, 0, 32'h08, 32'h0);
    check("deadbeef", dout[0], 32'hDEADBEEF);
    access(1, 0, 32'h0C, 32'h0);
    access(0, 0, 32'h0A, 32'h0);
    access(0, 0, 32'h08, 32'h0);
    access(0, 2, 32'h08, 32'h0);
    access(0, 1, 32'h104, 32'hCAFEF00D);
    access(0, 0, 32'h04, 32'h0);
    check("wrap_read", dout[0], 32'hCAFEF00D);

    // Reset in the middle of a store's wait states discards it.
    daddr[0] = 32'h10; din[0] = 32'h12345678; wr[0] = 1'b0; rd[0] = 1'b1;
    #1;
    @(posedge clk); #1;
    check("mid_wait_busy", 32'(busy[0]), 32'd1);
    wr[0] = 1'b1;
    rst[0] = 1'b1;
    #1;
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_dout", dout[0], 32'd0);
    dout_m[0] = '0;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    access(0, 0, 32'h10, 32'h0);

    // sw then lw back-to-back, as the control unit would issue them.
    for (int d = 0; d < 2; d++) begin
      access(d, 1, 32'h20, 32'hA5C3_0F96);
      access(d, 0, 32'h20, 32'h0);
      check("sw_lw", dout[d], 32'hA5C3_0F96);
    end

    // Randomized traffic across both DUTs.
    for (int d = 0; d < 2; d++) begin
      repeat (150) begin
        r = $urandom_range(0, 9);
        a = 32'($urandom_range(0, 1023));
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        access(d, (r < 4) ? 0 : (r < 8) ? 1 : 2, a, $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder on the other end of the control unit's active-low RD/WR strobes.
- Serves word loads and stores from the ALU-computed address, with a configurable number of wait states.
- Drives Busy so the CPU holds PCWre low until the access completes.
- Sits between the ALU result bus, the register-file read port (store data) and the DBDataSrc write-back mux (load data).

Parameters:
- DEPTH, 256, memory size in bytes; power of two, minimum 8.
- WAIT_CYCLES, 2, wait states inserted between accepting a request and responding; range 0..15.

Ports:
- CLK  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- RD  input  1  active-low read strobe from the control unit; only a literal 0 counts as a request.
- WR  input  1  active-low write strobe from the control unit; only a literal 0 counts as a request.
- DAddr  input  32  byte address (ALU result).
- DataIn  input  32  store data (rt register).
- DataOut  output  32  registered load data.
- Busy  output  1  combinational stall request to the PC/control path.
- Done  output  1  one-cycle pulse when an access completes.
- AddrErr  output  1  one-cycle pulse when an access is rejected as misaligned.
- ProtoErr  output  1  one-cycle pulse when RD and WR are both low.

Behaviour:
- Reset (async, high): state=IDLE, wait counter=0, DataOut=0, Done=0, AddrErr=0, ProtoErr=0. Memory array contents are not cleared. Reset mid-access aborts it; a pending write is discarded.
- Request: in IDLE, req = (RD==0) xor (WR==0).
- Both low in IDLE: no access. ProtoErr pulses on the next cycle; state stays IDLE; Busy stays 0.
- FSM states: IDLE, WAIT, RESP.
  - IDLE & req & DAddr[1:0]==0: latch op, address and DataIn; counter=WAIT_CYCLES; go to WAIT, or straight to RESP if WAIT_CYCLES==0.
  - IDLE & req & DAddr[1:0]!=0: no access. AddrErr pulses on the next cycle; go to RESP so the CPU still advances.
  - WAIT: decrement counter; go to RESP when counter reaches 1 (i.e. after WAIT_CYCLES cycles in WAIT).
  - RESP: always go to IDLE. RD/WR are ignored here; the same instruction is still presented.
- Busy = (state==IDLE & req & exactly one strobe low) | (state==WAIT). It is 0 in RESP. Total stall per access = 1 + WAIT_CYCLES cycles, and the PC advances at the edge that ends RESP.
- Done: registered, high exactly during the RESP cycle of a valid access. Not asserted for a misaligned request.
- Store: written at the clock edge entering RESP. Byte address a = DAddr mod DEPTH. Big-endian: mem[a]=D[31:24], mem[a+1]=D[23:16], mem[a+2]=D[15:8], mem[a+3]=D[7:0].
- Load: DataOut updated at the edge entering RESP, same byte order. Held until the next successful load; stores and errors leave it unchanged.
- Addresses at or above DEPTH wrap modulo DEPTH. Alignment is checked before the wrap.
- Read-after-write on back-to-back instructions returns the new data, since the write completes in an earlier cycle.

Decomposition:
- Shared package dmem_pkg:
  - state encoding IDLE=2'b00, WAIT=2'b01, RESP=2'b10;
  - constants STROBE_ACTIVE=1'b0 and BYTES_PER_WORD=4;
  - the control unit's opcode constants for sw/lw (100110/100111), for benches.
- One natural sub-module, dmem_byte_array:
  - DEPTH x 8 storage;
  - 4-byte big-endian write port with enable;
  - registered 4-byte read port;
  - no reset on storage.
- The FSM, counter and flags stay in data_mem_responder.

Test Plan:
- WR=0, DAddr=0x08, DataIn=0xDEADBEEF, WAIT_CYCLES=2 -> Busy high for 3 cycles, Done pulses 1 cycle. Then RD=0, DAddr=0x08 -> DataOut=0xDEADBEEF; bytes mem[8..11]=DE,AD,BE,EF.
- WAIT_CYCLES=0: RD=0, DAddr=0x0C -> Busy high exactly 1 cycle, Done in the next cycle, DataOut valid with Done.
- RD=0, DAddr=0x0A -> AddrErr pulses 1 cycle, Done=0, DataOut unchanged, memory unchanged, FSM back in IDLE after RESP.
- RD=0 and WR=0 together -> ProtoErr pulses, Busy=0, no memory change. DAddr=0x104 with DEPTH=256 -> access hits byte 0x04 (wrap).
- Reset asserted mid-WAIT of a write of 0x12345678 to 0x10 -> immediate IDLE, Busy=0, DataOut=0. A subsequent read of 0x10 returns the prior contents, not 0x12345678.
- Mimic control-unit timing: sw then lw back-to-back at 0x20 with RD/WR held through RESP -> exactly one access each, no duplicate request, lw returns the stored value.
